// File: rtl/bcd_multi_seq_display_if.sv
// Bus bundle for bcd_multi_seq_display: conversion request/status plus the pixel lookup path.
interface bcd_multi_seq_display_if #(
  parameter int NUM_CH       = 2,
  parameter int VAL_W        = 16,
  parameter int SCREEN_WIDTH = 10,
  parameter int PIXEL_WIDTH  = 12
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                    start;
  logic [NUM_CH*VAL_W-1:0] value;
  logic                    busy;
  logic                    done;
  logic                    pix_on;
  logic [CH_W-1:0]         pix_ch;
  logic [SCREEN_WIDTH-1:0] pix_x;
  logic [2:0]              pix_y;
  logic [PIXEL_WIDTH-1:0]  background_rgb;
  logic [PIXEL_WIDTH-1:0]  rgb;

  modport master (
    output start, value, pix_on, pix_ch, pix_x, pix_y, background_rgb,
    input  busy, done, rgb
  );

  modport slave (
    input  start, value, pix_on, pix_ch, pix_x, pix_y, background_rgb,
    output busy, done, rgb
  );
endinterface

// File: rtl/bcd_multi_seq_display.sv
// Snapshots NUM_CH values, converts each by iterative double-dabble into a shadow bank, commits atomically, renders 8x8 glyphs.
// done follows start by NUM_CH*(VAL_W+2)+1 cycles; start while busy is dropped; BCD_LEADING_ZERO_BLANK_EN blanks leading zeros.
module bcd_multi_seq_display #(
  parameter int                     NUM_CH       = 2,
  parameter int                     VAL_W        = 16,
  parameter int                     DIGITS       = 5,
  parameter bit                     SIGNED       = 1'b1,
  parameter int                     SCREEN_WIDTH = 10,
  parameter int                     PIXEL_WIDTH  = 12,
  parameter logic [PIXEL_WIDTH-1:0] FG_COLOR     = 12'h5FF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  bcd_multi_seq_display_if.slave   bus
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DIG_W = DIGITS * 4;
  localparam int ACC_W = DIG_W + 4;
  localparam int CNT_W = $clog2(VAL_W + 1);

`ifdef BCD_LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_STORE, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [NUM_CH*VAL_W-1:0] snap_q, snap_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic                    neg_q, neg_d;
  logic [VAL_W-1:0]        mag_q, mag_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic                    lost_q, lost_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DIG_W-1:0]        sh_dig_q [NUM_CH];
  logic [DIG_W-1:0]        sh_dig_d [NUM_CH];
  logic [DIG_W-1:0]        dp_dig_q [NUM_CH];
  logic [DIG_W-1:0]        dp_dig_d [NUM_CH];
  logic [NUM_CH-1:0]       sh_neg_q, sh_neg_d, sh_ovf_q, sh_ovf_d;
  logic [NUM_CH-1:0]       dp_neg_q, dp_neg_d, dp_ovf_q, dp_ovf_d;

  logic [VAL_W-1:0]        cur;
  logic [ACC_W-1:0]        adj;
  logic                    busy, done;

  assign cur = snap_q[int'(ch_q)*VAL_W +: VAL_W];

  always_comb begin
    adj = acc_q;
    for (int i = 0; i <= DIGITS; i++) begin
      if (acc_q[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = acc_q[i*4 +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    ch_d     = ch_q;
    neg_d    = neg_q;
    mag_d    = mag_q;
    acc_d    = acc_q;
    lost_d   = lost_q;
    cnt_d    = cnt_q;
    sh_dig_d = sh_dig_q;
    sh_neg_d = sh_neg_q;
    sh_ovf_d = sh_ovf_q;
    dp_dig_d = dp_dig_q;
    dp_neg_d = dp_neg_q;
    dp_ovf_d = dp_ovf_q;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          snap_d  = bus.value;
          ch_d    = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        busy    = 1'b1;
        neg_d   = SIGNED && cur[VAL_W-1];
        mag_d   = (SIGNED && cur[VAL_W-1]) ? (~cur) + VAL_W'(1) : cur;
        acc_d   = '0;
        lost_d  = 1'b0;
        cnt_d   = CNT_W'(VAL_W);
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        busy   = 1'b1;
        // a 1 leaving the guard nibble is a magnitude too large to display
        lost_d = lost_q | adj[ACC_W-1];
        acc_d  = {adj[ACC_W-2:0], mag_q[VAL_W-1]};
        mag_d  = {mag_q[VAL_W-2:0], 1'b0};
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_STORE;
      end
      S_STORE: begin
        busy           = 1'b1;
        sh_dig_d[ch_q] = acc_q[DIG_W-1:0];
        sh_neg_d[ch_q] = neg_q;
        sh_ovf_d[ch_q] = lost_q | (|acc_q[ACC_W-1 -: 4]);
        if (ch_q == CH_W'(NUM_CH - 1)) begin
          state_d = S_DONE;
        end else begin
          ch_d    = ch_q + CH_W'(1);
          state_d = S_LOAD;
        end
      end
      S_DONE: begin
        done     = 1'b1;
        dp_dig_d = sh_dig_q;
        dp_neg_d = sh_neg_q;
        dp_ovf_d = sh_ovf_q;
        if (bus.start) begin
          snap_d  = bus.value;
          ch_d    = '0;
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      snap_q   <= '0;
      ch_q     <= '0;
      neg_q    <= 1'b0;
      mag_q    <= '0;
      acc_q    <= '0;
      lost_q   <= 1'b0;
      cnt_q    <= '0;
      sh_dig_q <= '{default: '0};
      dp_dig_q <= '{default: '0};
      sh_neg_q <= '0;
      sh_ovf_q <= '0;
      dp_neg_q <= '0;
      dp_ovf_q <= '0;
    end else begin
      state_q  <= state_d;
      snap_q   <= snap_d;
      ch_q     <= ch_d;
      neg_q    <= neg_d;
      mag_q    <= mag_d;
      acc_q    <= acc_d;
      lost_q   <= lost_d;
      cnt_q    <= cnt_d;
      sh_dig_q <= sh_dig_d;
      dp_dig_q <= dp_dig_d;
      sh_neg_q <= sh_neg_d;
      sh_ovf_q <= sh_ovf_d;
      dp_neg_q <= dp_neg_d;
      dp_ovf_q <= dp_ovf_d;
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;

  // Rows packed top row first: row y lives in bits [y*8 +: 8], MSB is the leftmost pixel.
  function automatic logic [63:0] glyph_rows(input logic [3:0] code);
    case (code)
      4'd0:    glyph_rows = 64'h3C666E7666663C00;
      4'd1:    glyph_rows = 64'h381818181818_7E00;
      4'd2:    glyph_rows = 64'h3C66060C30607E00;
      4'd3:    glyph_rows = 64'h3C66061C06663C00;
      4'd4:    glyph_rows = 64'h0C1C3C6C7E0C0C00;
      4'd5:    glyph_rows = 64'h7E607C0606663C00;
      4'd6:    glyph_rows = 64'h3C607C6666663C00;
      4'd7:    glyph_rows = 64'h7E060C1830303000;
      4'd8:    glyph_rows = 64'h3C66663C66663C00;
      4'd9:    glyph_rows = 64'h3C66663E060C3800;
      4'd10:   glyph_rows = 64'h0000007E00000000;
      default: glyph_rows = 64'h0;
    endcase
  endfunction

  logic [SCREEN_WIDTH-1:0] slot;
  logic [2:0]              col;
  logic                    ch_ok;
  logic [3:0]              code;
  logic [63:0]             glyph;
  logic [7:0]              row;
  logic                    pix_bit;
  int                      nib;

  assign slot = bus.pix_x >> 3;
  assign col  = bus.pix_x[2:0];

  generate
    if ((1 << CH_W) == NUM_CH) begin : g_ch_full
      assign ch_ok = 1'b1;
    end else begin : g_ch_part
      assign ch_ok = (bus.pix_ch < CH_W'(NUM_CH));
    end
  endgenerate

  always_comb begin
    code = 4'd15;
    nib  = 0;
    if (bus.pix_on && ch_ok && (slot <= SCREEN_WIDTH'(DIGITS))) begin
      nib = DIGITS - int'(slot);
      if (dp_ovf_q[bus.pix_ch]) begin
        code = 4'd10;
      end else if (slot == '0) begin
        code = dp_neg_q[bus.pix_ch] ? 4'd10 : 4'd15;
      end else begin
        code = dp_dig_q[bus.pix_ch][nib*4 +: 4];
        if (LZB && (nib != 0) && ((dp_dig_q[bus.pix_ch] >> (nib*4)) == '0)) code = 4'd15;
      end
    end
    glyph   = glyph_rows(code);
    row     = glyph[{bus.pix_y, 3'b000} +: 8];
    pix_bit = row[3'd7 - col];
  end

  assign bus.rgb = pix_bit ? FG_COLOR : bus.background_rgb;

endmodule

// File: doc/bcd_multi_seq_display.md
Name: bcd_multi_seq_display

Overview:
- Multi-channel signed-decimal display controller for the VGA pixel path.
- Snapshots NUM_CH binary values on a start pulse, then converts each one sequentially with an iterative double-dabble engine, one shift per clock.
- Results go into a shadow bank; the shadow bank is committed atomically to a display bank.
- The display bank drives combinational 8x8-glyph pixel rendering, so the screen never shows a partially converted value.

Parameters:
- NUM_CH, 2: number of value channels.
- VAL_W, 16: bits per channel value.
- DIGITS, 5: decimal digits per channel.
- SIGNED, 1: 1 treats values as two's complement; 0 treats them as unsigned.
- SCREEN_WIDTH, 10: pixel coordinate width.
- PIXEL_WIDTH, 12: RGB width.
- FG_COLOR, 12'h5FF: glyph colour.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  conversion request pulse.
- value  in  NUM_CH*VAL_W  channel c occupies bits [c*VAL_W +: VAL_W].
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse when the display bank has been updated.
- pix_on  in  1  the current pixel lies inside a number field.
- pix_ch  in  max(1,$clog2(NUM_CH))  channel being drawn.
- pix_x  in  SCREEN_WIDTH  x offset inside the field.
- pix_y  in  3  glyph row, 0 = bottom row.
- background_rgb  in  PIXEL_WIDTH  pass-through colour.
- rgb  out  PIXEL_WIDTH  output pixel colour.

Behaviour:
- Reset (asynchronous, rst_n low):
  - State is IDLE; busy=0, done=0.
  - Shadow and display banks are cleared: all digits 0, sign 0, ovf 0.
  - Reset asserted mid-conversion aborts the conversion, and the display bank still clears.
- States: IDLE, LOAD, SHIFT, STORE, DONE.
- IDLE/DONE, start=1:
  - Register the whole value bus into a snapshot register.
  - Set channel index ch=0 and go to LOAD.
  - busy=1 from the next cycle onward.
- start while in LOAD, SHIFT or STORE is ignored; there is no queueing.
- LOAD (1 cycle):
  - Sign: neg = SIGNED and snapshot[ch] MSB is 1.
  - Magnitude: mag = two's-complement negation of snapshot[ch] if neg, else snapshot[ch], kept VAL_W bits wide unsigned. The most negative input gives 2^(VAL_W-1) and is legal.
  - Clear the BCD accumulator, which is DIGITS*4+4 bits (one spare guard digit).
  - Load shift counter = VAL_W.
- SHIFT (VAL_W cycles). Each cycle:
  - Add 3 to every accumulator nibble (guard nibble included) whose value is >=5.
  - Then shift {accumulator, mag} left by 1.
  - Decrement the counter; on the last shift go to STORE.
- STORE (1 cycle):
  - Write the DIGITS nibbles and neg into shadow[ch].
  - Set ovf[ch] if the guard nibble, or the bits shifted out above it, are nonzero.
  - If ch==NUM_CH-1 go to DONE; else increment ch and go to LOAD.
- DONE (1 cycle):
  - Copy the shadow bank to the display bank.
  - done=1, busy=0.
  - Go to IDLE, or to LOAD if start=1 in this cycle.
- Latency: done rises exactly NUM_CH*(VAL_W+2)+1 cycles after the cycle start is sampled; 37 cycles at the defaults.
- Rendering is combinational from the display bank and the pix_* inputs; it adds no latency.
  - slot = pix_x >> 3 and col = pix_x[2:0].
  - Slot 0 is the sign slot: minus glyph if neg, else blank.
  - Slots 1..DIGITS hold digits from most significant to least significant.
  - Slots > DIGITS, pix_on=0, or pix_ch >= NUM_CH give background_rgb.
  - The glyph pixel is bitmap_row[7-col], so the leftmost pixel is the MSB.
  - Glyph codes: 0-9 are digits, 10 is minus, any other code is blank.
  - rgb = FG_COLOR where the glyph bit is 1, else background_rgb.
- Overflow: if ovf[ch] is set, every slot 0..DIGITS of that channel renders the minus glyph.

Optional Feature:
- Macro: BCD_LEADING_ZERO_BLANK_EN.
- Defined:
  - Zero digits to the left of the most significant nonzero digit render blank (background).
  - The least significant digit always renders, so value 0 shows a single '0'.
  - The minus sign stays in slot 0.
- Undefined: all DIGITS digits render, including leading zeros.

Test Plan:
- Conversion and latency:
  - Stimulus: defaults, ch0=12345, ch1=0, pulse start.
  - Response: done high exactly 37 cycles later, busy high for the 36 cycles before it.
  - Response: ch0 slots 1..5 = 1,2,3,4,5, slot 0 blank; row 7 of slot 1 shows 8'b00111000.
- Signed extremes:
  - Stimulus: ch0=16'h8000, ch1=16'hFFFF.
  - Response: ch0 = minus,3,2,7,6,8; ch1 = minus,0,0,0,0,1 (macro undefined).
- Atomic commit and busy rules:
  - Stimulus: first convert 111/222; then start 999/888; pulse start again mid-SHIFT.
  - Response: the display keeps 111/222 until the DONE cycle, then shows 999/888.
  - Response: exactly one done pulse; the second start is ignored.
- Back-to-back start:
  - Stimulus: start=1 in the DONE cycle.
  - Response: a new conversion starts immediately; the next done comes 37 cycles later.
- Reset:
  - Stimulus: rst_n low at cycle 10 of a conversion.
  - Response: busy=0, done=0, the display shows zeros.
  - Response: a later start converts correctly.
- Overflow and blanking:
  - Overflow stimulus: DIGITS=4, ch0=12345. Response: slots 0..4 all minus.
  - Blanking stimulus: with BCD_LEADING_ZERO_BLANK_EN, ch0=7 and ch1=0.
  - Blanking response: ch0 slots 1-4 show background and slot 5 shows '7'; ch1 shows only slot 5 '0'.
